particle_plotter: RTL and testbench



---
 rtl/particle_plotter_pkg.sv | 31 +++
 rtl/particle_plotter_if.sv | 25 ++
 rtl/particle_plotter_row_scanner.sv | 40 ++++
 rtl/particle_plotter.sv | 129 ++++++++++++
 tb/tb_particle_plotter.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/particle_plotter_pkg.sv
// Shared constants, draw-state encoding and coordinate-to-cell mapping for particle_plotter.
package particle_pkg;

    localparam int NUM_P      = 3;
    localparam int GRID       = 16;
    localparam int WIDTH      = 256;
    localparam int COORD_W    = 16;
    localparam int CELL_W     = $clog2(GRID);
    localparam int CELL_SHIFT = $clog2(WIDTH) - CELL_W;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CAPTURE = 3'd1,
        CLEAR   = 3'd2,
        PLOT    = 3'd3,
        SWAP    = 3'd4
    } draw_state_t;

    // Clamp a signed coordinate into 0..WIDTH-1, then keep the top CELL_W bits.
    function automatic logic [CELL_W-1:0] coord_to_cell(input logic signed [COORD_W-1:0] v);
        logic [COORD_W-1:0] c;
        if (v[COORD_W-1])
            c = '0;
        else if (v >= $signed(COORD_W'(WIDTH)))
            c = COORD_W'(WIDTH - 1);
        else
            c = v;
        return c[CELL_SHIFT +: CELL_W];
    endfunction

endpackage

// File: rtl/particle_plotter_if.sv
// Particle coordinate inputs, sample/status handshake and LED matrix drive for particle_plotter.
interface particle_plotter_if;
    import particle_pkg::*;

    // sample is a single-cycle request; it is honoured only while busy is low
    // and is never queued. frame_done pulses for one cycle when the new frame is live.
    logic signed [COORD_W-1:0] x0, y0, x1, y1, x2, y2;
    logic                      sample;
    logic                      busy;
    logic                      frame_done;
    logic [CELL_W-1:0]         row_sel;
    logic [GRID-1:0]           col_data;
    draw_state_t               dbg_state;

    modport master (
        output x0, y0, x1, y1, x2, y2, sample,
        input  busy, frame_done, row_sel, col_data, dbg_state
    );

    modport slave (
        input  x0, y0, x1, y1, x2, y2, sample,
        output busy, frame_done, row_sel, col_data, dbg_state
    );

endinterface

// File: rtl/particle_plotter_row_scanner.sv
// Free-running matrix row scanner: dwell counter, row select and registered column data.
module row_scanner
    import particle_pkg::*;
#(
    parameter int ROW_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [GRID-1:0]   i_front_row,
    output logic [CELL_W-1:0] o_row_sel,
    output logic [GRID-1:0]   o_col_data
);

    localparam int DW = (ROW_CYCLES > 1) ? $clog2(ROW_CYCLES) : 1;

    logic [DW-1:0]     r_dwell;
    logic [CELL_W-1:0] r_row_sel;
    logic [GRID-1:0]   r_col_data;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_dwell    <= '0;
            r_row_sel  <= '0;
            r_col_data <= '0;
        end else begin
            // Row index wraps naturally at GRID since it is CELL_W bits wide.
            if (r_dwell == DW'(ROW_CYCLES - 1)) begin
                r_dwell   <= '0;
                r_row_sel <= r_row_sel + 1'b1;
            end else begin
                r_dwell <= r_dwell + 1'b1;
            end
            r_col_data <= i_front_row;
        end
    end

    assign o_row_sel  = r_row_sel;
    assign o_col_data = r_col_data;

endmodule

// File: rtl/particle_plotter.sv
// Double-buffered 16x16 particle renderer; define PLOTTER_TRAIL_EN to keep old pixels as motion trails.
module particle_plotter
    import particle_pkg::*;
#(
    parameter int ROW_CYCLES = 1024
) (
    input  logic             clk,
    input  logic             reset,
    particle_plotter_if.slave bus
);

    draw_state_t       r_state;
    logic [CELL_W-1:0] r_idx;
    logic [1:0]        r_pidx;
    logic              r_front;
    logic              r_busy;
    logic              r_frame_done;
    logic [GRID-1:0]   r_buf [2][GRID];
    logic [CELL_W-1:0] r_col [NUM_P];
    logic [CELL_W-1:0] r_row [NUM_P];

    logic                      w_back;
    logic [GRID-1:0]           w_clear_row;
    logic [GRID-1:0]           w_front_row;
    logic [CELL_W-1:0]         w_row_sel;
    logic [GRID-1:0]           w_col_data;
    logic signed [COORD_W-1:0] w_x [NUM_P];
    logic signed [COORD_W-1:0] w_y [NUM_P];

    assign w_back = ~r_front;
    assign w_x[0] = bus.x0;
    assign w_y[0] = bus.y0;
    assign w_x[1] = bus.x1;
    assign w_y[1] = bus.y1;
    assign w_x[2] = bus.x2;
    assign w_y[2] = bus.y2;

`ifdef PLOTTER_TRAIL_EN
    assign w_clear_row = r_buf[r_front][r_idx];
`else
    assign w_clear_row = '0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_idx        <= '0;
            r_pidx       <= '0;
            r_front      <= 1'b0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
            for (int b = 0; b < 2; b++)
                for (int r = 0; r < GRID; r++)
                    r_buf[b][r] <= '0;
            for (int p = 0; p < NUM_P; p++) begin
                r_col[p] <= '0;
                r_row[p] <= '0;
            end
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.sample) begin
                        r_state <= CAPTURE;
                        r_busy  <= 1'b1;
                    end
                end
                CAPTURE: begin
                    // Rows count down from the top so that +y points up on the matrix.
                    for (int p = 0; p < NUM_P; p++) begin
                        r_col[p] <= coord_to_cell(w_x[p]);
                        r_row[p] <= CELL_W'(GRID - 1) - coord_to_cell(w_y[p]);
                    end
                    r_idx   <= '0;
                    r_state <= CLEAR;
                end
                CLEAR: begin
                    r_buf[w_back][r_idx] <= w_clear_row;
                    if (r_idx == CELL_W'(GRID - 1)) begin
                        r_idx   <= '0;
                        r_pidx  <= '0;
                        r_state <= PLOT;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                PLOT: begin
                    r_buf[w_back][r_row[r_pidx]][r_col[r_pidx]] <= 1'b1;
                    // Front flips on entry to SWAP so the scanner picks it up one cycle later.
                    if (r_pidx == 2'(NUM_P - 1)) begin
                        r_front      <= w_back;
                        r_frame_done <= 1'b1;
                        r_state      <= SWAP;
                    end else begin
                        r_pidx <= r_pidx + 1'b1;
                    end
                end
                SWAP: begin
                    r_frame_done <= 1'b0;
                    r_busy       <= 1'b0;
                    r_state      <= IDLE;
                end
                default: begin
                    r_state      <= IDLE;
                    r_busy       <= 1'b0;
                    r_frame_done <= 1'b0;
                end
            endcase
        end
    end

    assign w_front_row = r_buf[r_front][w_row_sel];

    row_scanner #(
        .ROW_CYCLES (ROW_CYCLES)
    ) u_row_scanner (
        .clk         (clk),
        .reset       (reset),
        .i_front_row (w_front_row),
        .o_row_sel   (w_row_sel),
        .o_col_data  (w_col_data)
    );

    assign bus.busy       = r_busy;
    assign bus.frame_done = r_frame_done;
    assign bus.row_sel    = w_row_sel;
    assign bus.col_data   = w_col_data;
    assign bus.dbg_state  = r_state;

endmodule

// File: tb/tb_particle_plotter.sv
// Directed bench for particle_plotter: frame timing, mapping, busy handling, scanner and reset.
module tb_particle_plotter;
    import particle_pkg::*;

    localparam int ROW_CYC = 4;

    logic clk = 1'b0;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;
    logic [31:0] exp_q[$];

    particle_plotter_if bus();

    particle_plotter #(
        .ROW_CYCLES (ROW_CYC)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    task automatic do_reset();
        reset = 1'b0;
        bus.sample = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    // ---------------- checking ----------------
    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- drivers ----------------
    task automatic set_parts(input int xa, input int ya, input int xb, input int yb,
                             input int xc, input int yc);
        bus.x0 = 16'(xa); bus.y0 = 16'(ya);
        bus.x1 = 16'(xb); bus.y1 = 16'(yb);
        bus.x2 = 16'(xc); bus.y2 = 16'(yc);
    endtask

    // Raises sample for cycle N; returns at the negedge inside cycle N+1 (CAPTURE).
    task automatic pulse_sample();
        @(negedge clk);
        bus.sample = 1'b1;
        @(negedge clk);
        bus.sample = 1'b0;
    endtask

    // Called in cycle N+1; returns k such that frame_done is seen in cycle N+k (0 = timeout).
    task automatic wait_done(input bit scramble, output int cyc);
        cyc = 0;
        for (int k = 1; k <= 60; k++) begin
            if (bus.frame_done === 1'b1) begin
                cyc = k;
                break;
            end
            if (scramble && k == 2)
                set_parts(-100, 999, 77, 3, 200, 40);
            @(negedge clk);
        end
    endtask

    task automatic frame(input string tag, input bit scramble);
        int cyc;
        pulse_sample();
        wait_done(scramble, cyc);
        check_val({tag, "_done_latency"}, 32'(cyc), 32'd21);
        @(negedge clk);
        check_val({tag, "_busy_fall"}, 32'(bus.busy), 32'd0);
    endtask

    // ---------------- scoreboard ----------------
    task automatic push_exp(input int r0, input logic [15:0] v0, input int r1,
                            input logic [15:0] v1, input int r2, input logic [15:0] v2);
        for (int r = 0; r < GRID; r++) begin
            logic [15:0] v;
            v = '0;
            if (r == r0) v = v | v0;
            if (r == r1) v = v | v1;
            if (r == r2) v = v | v2;
            exp_q.push_back(32'(v));
        end
    endtask

    // A row is sampled once row_sel has held for a full cycle, so col_data reflects it.
    task automatic read_compare(input string tag);
        logic [15:0] rows [GRID];
        logic [GRID-1:0] seen;
        logic [CELL_W-1:0] prev;
        seen = '0;
        for (int r = 0; r < GRID; r++) rows[r] = '0;
        for (int k = 0; k < 120 && seen != '1; k++) begin
            prev = bus.row_sel;
            @(negedge clk);
            if (bus.row_sel == prev) begin
                rows[bus.row_sel] = bus.col_data;
                seen[bus.row_sel] = 1'b1;
            end
        end
        check_val({tag, "_rows_seen"}, 32'(seen), 32'hFFFF);
        for (int r = 0; r < GRID; r++) begin
            logic [31:0] e;
            e = exp_q.pop_front();
            check_val($sformatf("%s_row%0d", tag, r), 32'(rows[r]), e);
        end
    endtask

    // ---------------- tests ----------------
    initial begin
        set_parts(0, 0, 0, 0, 0, 0);
        do_reset();

        // Reset state
        check_val("rst_busy", 32'(bus.busy), 32'd0);
        check_val("rst_frame_done", 32'(bus.frame_done), 32'd0);
        check_val("rst_row_sel", 32'(bus.row_sel), 32'd0);
        check_val("rst_col_data", 32'(bus.col_data), 32'd0);
        check_val("rst_state", 32'(bus.dbg_state), 32'(IDLE));

        // Scanner stepping: row advances every ROW_CYC cycles and wraps to 0
        for (int k = 1; k <= 68; k++) begin
            @(negedge clk);
            check_val($sformatf("scan_k%0d", k), 32'(bus.row_sel), 32'((k / ROW_CYC) % GRID));
        end

        // Basic plot; inputs scrambled after CAPTURE must not affect the frame
        do_reset();
        set_parts(128, 128, 0, 0, 255, 255);
        pulse_sample();
        check_val("basic_busy_rise", 32'(bus.busy), 32'd1);
        check_val("basic_state_capture", 32'(bus.dbg_state), 32'(CAPTURE));
        begin
            int cyc;
            wait_done(1'b1, cyc);
            check_val("basic_done_latency", 32'(cyc), 32'd21);
            @(negedge clk);
            check_val("basic_busy_fall", 32'(bus.busy), 32'd0);
        end
        push_exp(7, 16'h0100, 15, 16'h0001, 0, 16'h8000);
        read_compare("basic");

        // Clamping
        do_reset();
        set_parts(-5, 300, 256, -1, 256, -1);
        frame("clamp", 1'b0);
        push_exp(0, 16'h0001, 15, 16'h8000, -1, 16'h0000);
        read_compare("clamp");

        // Busy handling: samples in cycles 0, 5 and 22
        do_reset();
        set_parts(16, 16, 16, 16, 16, 16);
        for (int c = 0; c < 46; c++) begin
            @(negedge clk);
            bus.sample = (c == 0 || c == 5 || c == 22);
            check_val($sformatf("busyh_fd_c%0d", c), 32'(bus.frame_done),
                      32'(c == 21 || c == 43));
            check_val($sformatf("busyh_busy_c%0d", c), 32'(bus.busy),
                      32'((c >= 1 && c <= 21) || (c >= 23 && c <= 43)));
        end
        bus.sample = 1'b0;

        // Reset mid-frame
        do_reset();
        set_parts(0, 0, 0, 0, 0, 0);
        frame("pre_rst", 1'b0);
        pulse_sample();
        repeat (9) @(negedge clk);
        check_val("midrst_busy_before", 32'(bus.busy), 32'd1);
        check_val("midrst_state_before", 32'(bus.dbg_state), 32'(CLEAR));
        reset = 1'b0;
        #1;
        check_val("midrst_busy", 32'(bus.busy), 32'd0);
        check_val("midrst_col_data", 32'(bus.col_data), 32'd0);
        check_val("midrst_row_sel", 32'(bus.row_sel), 32'd0);
        check_val("midrst_state", 32'(bus.dbg_state), 32'(IDLE));
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        set_parts(16, 16, 16, 16, 16, 16);
        frame("post_rst", 1'b0);
        push_exp(14, 16'h0002, -1, 16'h0000, -1, 16'h0000);
        read_compare("post_rst");

        // Trail build
        do_reset();
        set_parts(0, 0, 0, 0, 0, 0);
        frame("trail1", 1'b0);
        set_parts(32, 0, 32, 0, 32, 0);
        frame("trail2", 1'b0);
`ifdef PLOTTER_TRAIL_EN
        push_exp(15, 16'h0005, -1, 16'h0000, -1, 16'h0000);
`else
        push_exp(15, 16'h0004, -1, 16'h0000, -1, 16'h0000);
`endif
        read_compare("trail");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
